comb_eval_sequencer: RTL

- Sequences evaluation of a generated gate-level combinational netlist (combLogic-style: 2-input gates, feedback loops allowed) as a test-vector engine.
- Accepts one input vector per valid/ready handshake, drives it onto the netlist primary inputs and waits a programmable settle window.
- Then observes the single netlist output until it is stable for N consecutive cycles or a watchdog expires. Reports value, stability and oscillation/timeout status per vector.
- Sits between the vector source (bench or stimulus ROM) and the netlist under evaluation.

---
 rtl/comb_eval_pkg.sv | 24 ++
 rtl/sync2.sv | 24 ++
 rtl/comb_eval_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/comb_eval_pkg.sv
// Shared types and default parameter values for the combinational-netlist evaluation sequencer.
package comb_eval_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StObserve,
    StReport
  } state_e;

  typedef struct packed {
    logic value;
    logic stable;
    logic timeout;
  } result_t;

  localparam int unsigned DefNumIn     = 26;
  localparam int unsigned DefSettleCyc = 4;
  localparam int unsigned DefStableCnt = 3;
  localparam int unsigned DefMaxObs    = 16;
  localparam int unsigned DefCntW      = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous netlist output; both flops reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/comb_eval_sequencer.sv
// Test-vector engine: applies a vector to a combinational netlist, waits a settle window, then
// watches the synchronized output until it is stable or a watchdog expires, and reports it.
module comb_eval_sequencer
  import comb_eval_pkg::*;
#(
  parameter int unsigned NUM_IN     = DefNumIn,
  parameter int unsigned SETTLE_CYC = DefSettleCyc,
  parameter int unsigned STABLE_CNT = DefStableCnt,
  parameter int unsigned MAX_OBS    = DefMaxObs,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [NUM_IN-1:0] vec_data,
  input  logic              abort,
  output logic [NUM_IN-1:0] dut_in,
  input  logic              dut_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_value,
  output logic              res_stable,
  output logic              res_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  unstable_count
);

  localparam int unsigned WdW = $clog2(MAX_OBS + 1);

  state_e              state_q;
  logic [NUM_IN-1:0]   dut_in_q;
  result_t             res_q;
  logic                res_valid_q;
  logic [CNT_W-1:0]    vec_count_q;
  logic [CNT_W-1:0]    unstable_count_q;
  logic [7:0]          settle_q;
  logic [3:0]          run_q;
  logic [WdW-1:0]      wd_q;
  logic                prev_q;

  logic                sample;
  logic [3:0]          run_next;
  logic [WdW-1:0]      wd_next;
  logic                hit_stable;
  logic                hit_wd;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (dut_out),
    .q_o (sample)
  );

  // run_q == 0 marks the first OBSERVE sample, which always starts a fresh run.
  always_comb begin
    run_next = 4'd1;
    if (run_q != 4'd0 && sample == prev_q) run_next = run_q + 4'd1;
    wd_next    = wd_q + WdW'(1);
    hit_stable = (run_next == 4'(STABLE_CNT));
    hit_wd     = (wd_next == WdW'(MAX_OBS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      dut_in_q         <= '0;
      res_q            <= '0;
      res_valid_q      <= 1'b0;
      vec_count_q      <= '0;
      unstable_count_q <= '0;
      settle_q         <= '0;
      run_q            <= '0;
      wd_q             <= '0;
      prev_q           <= 1'b0;
    end else if (abort && state_q != StIdle) begin
      state_q     <= StIdle;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (vec_valid) begin
            dut_in_q <= vec_data;
            state_q  <= StApply;
          end
        end
        StApply: begin
          settle_q <= '0;
          run_q    <= '0;
          wd_q     <= '0;
          state_q  <= StSettle;
        end
        StSettle: begin
          if (settle_q == 8'(SETTLE_CYC - 1)) state_q <= StObserve;
          else settle_q <= settle_q + 8'd1;
        end
        StObserve: begin
          run_q  <= run_next;
          wd_q   <= wd_next;
          prev_q <= sample;
          // Stability takes priority when both criteria land on the same sample.
          if (hit_stable) begin
            res_q       <= '{value: sample, stable: 1'b1, timeout: 1'b0};
            res_valid_q <= 1'b1;
            state_q     <= StReport;
          end else if (hit_wd) begin
            res_q       <= '{value: sample, stable: 1'b0, timeout: 1'b1};
            res_valid_q <= 1'b1;
            state_q     <= StReport;
          end
        end
        StReport: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            vec_count_q <= vec_count_q + CNT_W'(1);
            if (res_q.timeout && unstable_count_q != '1) begin
              unstable_count_q <= unstable_count_q + CNT_W'(1);
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vec_ready      = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign dut_in         = dut_in_q;
  assign res_valid      = res_valid_q;
  assign res_value      = res_q.value;
  assign res_stable     = res_q.stable;
  assign res_timeout    = res_q.timeout;
  assign vec_count      = vec_count_q;
  assign unstable_count = unstable_count_q;

endmodule
